// File: rtl/piezo_pkg.sv
// Shared types for the piezo output stage: FSM states, request encoding
// and the request decoder used at the input register.
package piezo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POS  = 3'd1,
        ST_NEG  = 3'd2,
        ST_DEAD = 3'd3,
        ST_TRIP = 3'd4
    } drv_state_t;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'b00,
        REQ_NEG  = 2'b01,
        REQ_POS  = 2'b10,
        REQ_ILL  = 2'b11
    } req_t;

    // Mute wins over everything; the illegal 11 pattern decodes as idle.
    function automatic req_t decode_req(input logic p, input logic n, input logic mute);
        req_t r;
        if (mute) begin
            r = REQ_IDLE;
        end else begin
            case ({p, n})
                2'b10:   r = REQ_POS;
                2'b01:   r = REQ_NEG;
                default: r = REQ_IDLE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/piezo_wdog.sv
// Hold-time watchdog: counts cycles spent in one polarity and flags a trip
// on the last allowed cycle so the counter can never wrap.
module piezo_wdog
    import piezo_pkg::*;
#(
    parameter int MAX_HOLD = 32768
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic trip
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt_r;

    // Hold counter, saturating at the trip value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= {HW{1'b0}};
        end else if (clear) begin
            hold_cnt_r <= {HW{1'b0}};
        end else if (count_en && (hold_cnt_r != HOLD_LAST)) begin
            hold_cnt_r <= hold_cnt_r + {{(HW-1){1'b0}}, 1'b1};
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign trip = count_en && (hold_cnt_r == HOLD_LAST);

endmodule

// File: rtl/piezo_drv.sv
// Piezo H-bridge output stage: dead-time on polarity changes, volume PWM,
// mute, and a DC-hold watchdog that trips to a latched all-low state.
module piezo_drv
    import piezo_pkg::*;
#(
    parameter int DEAD_CYC = 8,
    parameter int MAX_HOLD = 32768
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       piezo_in,
    input  logic       piezo_n_in,
    input  logic       mute,
    input  logic [2:0] vol,
    input  logic       clr_fault,
    output logic       drv_p,
    output logic       drv_n,
    output logic       active,
    output logic       fault
);

    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);

    req_t          req_r;
    logic          ill_r;
    drv_state_t    state_r;
    drv_state_t    state_nx;
    logic [DW-1:0] dead_cnt_r;
    logic [2:0]    pwm_r;
    logic          polar_s;
    logic          trip_s;
    logic          fault_set_s;
    logic          drv_p_nx;
    logic          drv_n_nx;
    logic          drv_p_r;
    logic          drv_n_r;
    logic          active_r;
    logic          fault_r;

    // Input request register; the illegal 11 pattern is captured separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r <= REQ_IDLE;
            ill_r <= 1'b0;
        end else begin
            req_r <= decode_req(piezo_in, piezo_n_in, mute);
            ill_r <= piezo_in & piezo_n_in & ~mute;
        end
    end

    assign polar_s = (state_r == ST_POS) || (state_r == ST_NEG);

    piezo_wdog #(
        .MAX_HOLD (MAX_HOLD)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (~polar_s),
        .count_en (polar_s),
        .trip     (trip_s)
    );

    // Next-state logic; a polarity change always detours through DEAD.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_r == REQ_POS) begin
                    state_nx = ST_POS;
                end else if (req_r == REQ_NEG) begin
                    state_nx = ST_NEG;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_POS: begin
                if (req_r != REQ_POS) begin
                    state_nx = ST_DEAD;
                end else if (trip_s) begin
                    state_nx = ST_TRIP;
                end else begin
                    state_nx = ST_POS;
                end
            end
            ST_NEG: begin
                if (req_r != REQ_NEG) begin
                    state_nx = ST_DEAD;
                end else if (trip_s) begin
                    state_nx = ST_TRIP;
                end else begin
                    state_nx = ST_NEG;
                end
            end
            ST_DEAD: begin
                if (dead_cnt_r == DEAD_LAST) begin
                    case (req_r)
                        REQ_POS: state_nx = ST_POS;
                        REQ_NEG: state_nx = ST_NEG;
                        default: state_nx = ST_IDLE;
                    endcase
                end else begin
                    state_nx = ST_DEAD;
                end
            end
            ST_TRIP: begin
                if (req_r == REQ_IDLE) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_TRIP;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Fault sources and output leg drive for the coming cycle.
    always_comb begin
        fault_set_s = ill_r | (polar_s & (state_nx == ST_TRIP));
        drv_p_nx    = 1'b0;
        drv_n_nx    = 1'b0;
        if (state_r == ST_POS) begin
            drv_p_nx = (pwm_r <= vol);
        end else if (state_r == ST_NEG) begin
            drv_n_nx = (pwm_r <= vol);
        end else begin
            drv_p_nx = 1'b0;
            drv_n_nx = 1'b0;
        end
    end

    // State, dead-time and PWM counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dead_cnt_r <= {DW{1'b0}};
            pwm_r      <= 3'd0;
        end else begin
            state_r    <= state_nx;
            dead_cnt_r <= (state_r == ST_DEAD) ? dead_cnt_r + {{(DW-1){1'b0}}, 1'b1}
                                               : {DW{1'b0}};
            pwm_r      <= pwm_r + 3'd1;
        end
    end

    // Registered pins and sticky fault; a set beats a clear, TRIP ignores clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drv_p_r  <= 1'b0;
            drv_n_r  <= 1'b0;
            active_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            drv_p_r  <= drv_p_nx;
            drv_n_r  <= drv_n_nx;
            active_r <= polar_s;
            if (fault_set_s) begin
                fault_r <= 1'b1;
            end else if (clr_fault && (state_r != ST_TRIP)) begin
                fault_r <= 1'b0;
            end else begin
                fault_r <= fault_r;
            end
        end
    end

    assign drv_p  = drv_p_r;
    assign drv_n  = drv_n_r;
    assign active = active_r;
    assign fault  = fault_r;

endmodule

// File: doc/piezo_drv.md
# piezo_drv

Output stage between the tune sequencer and the piezo H-bridge pins. It takes the sequencer's `piezo`/`piezo_n` drive request and inserts a dead-time on every polarity change. It also applies a volume duty-cycle and mute, and trips to a safe all-low state if one polarity is held long enough to put DC across the element. All outputs are registered, so the pins never glitch.

## Interface
- `DEAD_CYC`, default 8: cycles both outputs are held low after leaving an active polarity (≥1).
- `MAX_HOLD`, default 32768: maximum continuous cycles in one polarity before a trip (≥2).
- `clk`  in  1  system clock, same domain as the sequencer.
- `rst`  in  1  reset, asynchronous, active-high.
- `piezo_in`  in  1  positive drive request from the sequencer.
- `piezo_n_in`  in  1  negative drive request from the sequencer.
- `mute`  in  1  forces the request to idle while high.
- `vol`  in  3  duty setting; on-fraction = (vol+1)/8.
- `clr_fault`  in  1  single-cycle pulse that clears `fault`.
- `drv_p`  out  1  positive bridge leg.
- `drv_n`  out  1  negative bridge leg.
- `active`  out  1  high while the block is in the POS or NEG state.
- `fault`  out  1  sticky flag: watchdog trip or illegal request seen.

## Operation
- **Request decode.** Inputs are registered once into `req`.
  - 10 → POS; 01 → NEG; 00 → IDLE.
  - 11 → treated as IDLE and sets `fault`.
  - `mute`=1 forces IDLE, overriding all other inputs.
- **State machine.** States are IDLE, POS, NEG, DEAD, TRIP.
  - IDLE: req POS → POS; req NEG → NEG. No dead-time is applied from IDLE.
  - POS: any req other than POS → DEAD.
  - NEG: any req other than NEG → DEAD.
  - DEAD: stays for exactly `DEAD_CYC` cycles, then goes to whatever req is current (POS, NEG or IDLE). Req changes during DEAD do not restart the count.
  - POS/NEG: hold counter reaches `MAX_HOLD`-1 while req is unchanged → TRIP, and `fault` is set.
  - TRIP: outputs low; goes to IDLE on the first cycle req is IDLE. Any other req keeps the block in TRIP.
- **Outputs.**
  - POS: `drv_p` = (pwm ≤ vol), `drv_n` = 0.
  - NEG: `drv_n` = (pwm ≤ vol), `drv_p` = 0.
  - All other states: both outputs 0.
  - `drv_p` and `drv_n` are never 1 together, under any input sequence.
- **PWM counter.** 3-bit, free-running, wraps 7→0. With vol=7 the output is high every cycle of POS/NEG.
- **Hold counter.** Width $clog2(MAX_HOLD). Cleared on every entry to POS or NEG. Counts only in POS/NEG. It never wraps, because the trip happens first.
- **`fault`.**
  - Set by a trip or by a 11 request.
  - Cleared by `clr_fault`, except while in TRIP (ignored there).
  - If a set and `clr_fault` occur in the same cycle, set wins.
- **`active`.** 1 in POS or NEG, independent of the PWM phase.

## Timing
- **Reset values.** All outputs 0; state IDLE; `req`, pwm and hold counter 0. Assertion of `rst` forces the outputs low immediately (asynchronous), including mid-note.
- **Latency.** A request change at input edge N (sampled into `req`) gives a state change at N+1 and a registered output at N+2.
  - IDLE→POS: `drv_p` first rises 2 cycles after `piezo_in` rises, when pwm ≤ vol.
  - POS→NEG: `drv_p` falls 2 cycles after the request changes. `drv_n` can rise no earlier than `DEAD_CYC` cycles after that.
- **Half-period shortening.** Each sequencer half-period is shortened by `DEAD_CYC` on the pins. This is accepted: it is negligible against periods of roughly 16k cycles.
- **Mute.** Asserting `mute` during POS/NEG passes through DEAD like any other request change.

## Structure
- **Package `piezo_pkg`.** Holds `drv_state_t` (IDLE, POS, NEG, DEAD, TRIP) and the request encoding enum `req_t`.
- **Sub-module `piezo_wdog`.** Contains the hold counter and trip compare: inputs clear and count-enable, output `trip`, parameter `MAX_HOLD`.
- **Top level.** Dead-time counter, PWM counter, FSM and output registers live in `piezo_drv`.

## Test plan
All scenarios use `DEAD_CYC`=8 and `MAX_HOLD`=32.

1. Reset, then idle requests → `drv_p`=`drv_n`=`active`=`fault`=0.
2. `rst` pulsed while `drv_p`=1 → `drv_p`=0 in the same cycle, without waiting for a clock edge.
3. vol=7, request 10 held 20 cycles then 01 → `drv_p` high from cycle 2 to cycle 21; both low for exactly 8 cycles; `drv_n` then rises; the two outputs never overlap.
4. vol=1, request 10 for 16 cycles → `drv_p` high for 2 of every 8 cycles, aligned to pwm 0–1; `active`=1 throughout.
5. Request 10 held 40 cycles → TRIP at hold count 31, outputs 0, `fault`=1. Then:
   - `clr_fault` pulsed while the request is still 10 → `fault` stays 1.
   - Request 00, then `clr_fault` → IDLE, `fault`=0.
6. Request 11 for 1 cycle → outputs stay 0 and `fault`=1. Separately, `mute`=1 during NEG → DEAD for 8 cycles, then IDLE.
